// File: rtl/crtc_rowdma.sv
// crtc_rowdma: double-buffered (ping-pong) character-row fetch DMA for the text CRTC.
// Define CRTC_ROWDMA_FAST_EN for one byte per granted cycle; otherwise legacy 2-cycle pacing.
module crtc_rowdma #(
  parameter int ADDR_W = 17,
  parameter int DEPTH  = 128,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              row_start,
  input  logic [ADDR_W-1:0] base_adr,
  input  logic [7:0]        row_len,
  output logic              busreq,
  input  logic              busack,
  output logic [ADDR_W-1:0] ram_adr,
  input  logic [7:0]        ram_data,
  input  logic [AW-1:0]     rd_adr,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              underrun
);

  // state | meaning
  // IDLE  | no fetch in progress
  // REQ   | bus requested, waiting for the first grant
  // XFER  | issuing reads; stalls while busack is low
  // DRAIN | final read issued, waiting to write its byte
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DRAIN} state_t;

  localparam logic [8:0]        DEPTH_L = 9'(DEPTH);
  localparam logic [ADDR_W-1:0] A_ONE   = 1;
  localparam logic [AW-1:0]     W_ONE   = 1;
  localparam logic [7:0]        C_ONE   = 8'd1;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_src;
  logic [ADDR_W-1:0]   r_row_base;
  logic [ADDR_W-1:0]   r_ram_adr;
  logic [7:0]          r_cnt;
  logic [7:0]          r_len;
  logic [AW-1:0]       r_wptr;
  logic                r_disp_bank;
  logic                r_pend;
  logic                r_busreq;
  logic                r_underrun;
  logic [7:0]          r_rd_data;
  logic [7:0]          r_buf [2*DEPTH];

  logic [7:0]          w_len;
  logic [ADDR_W-1:0]   w_next_base;
  logic                w_start;
  logic                w_wr;
  logic [AW:0]         w_wr_idx;

  assign w_len       = ({1'b0, row_len} > DEPTH_L) ? DEPTH_L[7:0] : row_len;
  assign w_next_base = r_row_base + ADDR_W'(r_len);
  assign w_start     = frame_start | row_start;
  // A byte still in flight when a new fetch starts belongs to the aborted row.
  assign w_wr        = r_pend & ~w_start;
  assign w_wr_idx    = {~r_disp_bank, r_wptr};

  assign busreq   = r_busreq;
  assign ram_adr  = r_ram_adr;
  assign rd_data  = r_rd_data;
  assign busy     = (r_state != S_IDLE);
  assign underrun = r_underrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_src       <= '0;
      r_row_base  <= '0;
      r_ram_adr   <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_wptr      <= '0;
      r_disp_bank <= 1'b0;
      r_pend      <= 1'b0;
      r_busreq    <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_busreq <= (r_state != S_IDLE);
      if (w_start) begin
        if (frame_start) begin
          r_src       <= base_adr;
          r_row_base  <= base_adr;
          r_disp_bank <= 1'b1;
          r_underrun  <= 1'b0;
        end else begin
          r_src       <= w_next_base;
          r_row_base  <= w_next_base;
          r_disp_bank <= ~r_disp_bank;
          if (r_state != S_IDLE) r_underrun <= 1'b1;
        end
        r_cnt   <= w_len;
        r_len   <= w_len;
        r_wptr  <= '0;
        r_pend  <= 1'b0;
        r_state <= (w_len == 8'd0) ? S_IDLE : S_REQ;
      end else begin
        if (r_pend) r_wptr <= r_wptr + W_ONE;
        unique case (r_state)
          S_REQ: begin
            if (busack) r_state <= S_XFER;
          end
          S_XFER: begin
`ifdef CRTC_ROWDMA_FAST_EN
            if (busack && r_cnt != 8'd0) begin
              r_ram_adr <= r_src;
              r_src     <= r_src + A_ONE;
              r_cnt     <= r_cnt - C_ONE;
              r_pend    <= 1'b1;
              if (r_cnt == C_ONE) r_state <= S_DRAIN;
            end else begin
              r_pend <= 1'b0;
            end
`else
            if (r_pend) begin
              r_pend <= 1'b0;
              r_cnt  <= r_cnt - C_ONE;
            end else if (busack && r_cnt != 8'd0) begin
              r_ram_adr <= r_src;
              r_src     <= r_src + A_ONE;
              r_pend    <= 1'b1;
              if (r_cnt == C_ONE) r_state <= S_DRAIN;
            end
`endif
          end
          S_DRAIN: begin
            r_pend  <= 1'b0;
`ifndef CRTC_ROWDMA_FAST_EN
            r_cnt   <= r_cnt - C_ONE;
`endif
            r_state <= S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_buf[w_wr_idx] <= ram_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_data <= '0;
    else        r_rd_data <= r_buf[{r_disp_bank, rd_adr}];
  end

endmodule
